// File: rtl/tanh_pkg.sv
// Shared types and constants for the CORDIC tanh stream adapter.
// Contents: data width, Q3.12 saturation constants and the sequencer state type.
package tanh_pkg;

    localparam int unsigned DATA_W = 16;

    // Q3.12 representations of +1.0 and -1.0
    localparam logic [DATA_W-1:0] TANH_ONE     = 16'h1000;
    localparam logic [DATA_W-1:0] TANH_NEG_ONE = 16'hF000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } tanh_state_t;

endpackage

// File: rtl/tanh_range_check.sv
// Combinational convergence-range classifier for a signed Q3.12 argument.
// Ports:
//   in_data   - argument, signed Q3.12
//   sat_limit - positive saturation magnitude, Q3.12
//   sat_pos   - in_data >= +sat_limit
//   sat_neg   - in_data <= -sat_limit
//   in_range  - neither saturation condition holds
module tanh_range_check
    import tanh_pkg::*;
(
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] sat_limit,
    output logic              sat_pos,
    output logic              sat_neg,
    output logic              in_range
);

    // One extra bit so the negated limit can never overflow
    logic signed [DATA_W:0] data_ext;
    logic signed [DATA_W:0] lim_ext;
    logic signed [DATA_W:0] neg_lim;

    always_comb begin
        data_ext = {in_data[DATA_W-1], in_data};
        lim_ext  = {1'b0, sat_limit};
        neg_lim  = -lim_ext;
        sat_pos  = (data_ext >= lim_ext);
        sat_neg  = (data_ext <= neg_lim);
        in_range = !(sat_pos || sat_neg);
    end

endmodule

// File: rtl/tanh_stream_adapter.sv
// Sequencer around the CORDIC tanh core: saturates out-of-range arguments,
// otherwise loads the core, releases its reset and captures the result on
// the first rising edge of the core flag. One operation in flight.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   in_valid/in_ready/in_data     - argument stream (signed Q3.12)
//   core_z0, core_rst             - core argument and core reset
//   core_out, core_flag           - core result and done level
//   out_valid/out_ready/out_data  - result stream (signed Q3.12)
//   out_sat, out_err              - bypass result / core timeout markers
module tanh_stream_adapter
    import tanh_pkg::*;
#(
    parameter logic [15:0] SAT_LIMIT = 16'h1199,
    parameter int unsigned RST_HOLD  = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] core_z0,
    output logic              core_rst,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              out_err
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT);

    tanh_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              flag_d_q, flag_d_d;
    logic [DATA_W-1:0] core_z0_q, core_z0_d;
    logic              in_ready_q, in_ready_d;
    logic              core_rst_q, core_rst_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;
    logic              out_err_q, out_err_d;

    logic sat_pos, sat_neg, in_range;
    logic accept;
    logic rise;

    tanh_range_check u_range (
        .in_data   (in_data),
        .sat_limit (SAT_LIMIT),
        .sat_pos   (sat_pos),
        .sat_neg   (sat_neg),
        .in_range  (in_range)
    );

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = to_cnt_q;
        flag_d_d    = 1'b0;
        core_z0_d   = core_z0_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        accept      = in_valid && in_ready_q;
        rise        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sat_pos) begin
                        out_data_d = TANH_ONE;
                        out_sat_d  = 1'b1;
                        out_err_d  = 1'b0;
                        state_d    = HOLD;
                    end else if (sat_neg) begin
                        out_data_d = TANH_NEG_ONE;
                        out_sat_d  = 1'b1;
                        out_err_d  = 1'b0;
                        state_d    = HOLD;
                    end else if (in_range) begin
                        core_z0_d  = in_data;
                        hold_cnt_d = '0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                    to_cnt_d = '0;
                    state_d  = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // flag_d only tracks the core while running, so it is zero on RUN entry
                flag_d_d = core_flag;
                rise     = core_flag && !flag_d_q;
                if (rise) begin
                    out_data_d = core_out;
                    out_sat_d  = 1'b0;
                    out_err_d  = 1'b0;
                    state_d    = HOLD;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
                    out_err_d  = 1'b1;
                    state_d    = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake/control outputs registered from the next state
        in_ready_d  = (state_d == IDLE);
        core_rst_d  = (state_d != RUN);
        out_valid_d = (state_d == HOLD);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            flag_d_q    <= 1'b0;
            core_z0_q   <= '0;
            in_ready_q  <= 1'b1;
            core_rst_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            flag_d_q    <= flag_d_d;
            core_z0_q   <= core_z0_d;
            in_ready_q  <= in_ready_d;
            core_rst_q  <= core_rst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign core_z0   = core_z0_q;
    assign core_rst  = core_rst_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_tanh_stream_adapter.sv
// Self-checking bench for tanh_stream_adapter: directed boundary cases plus
// randomized arguments against a behavioural model of the adapter, with a
// simple core model that raises its flag a chosen number of cycles after release.
module tb_tanh_stream_adapter;

    localparam int RST_HOLD = 2;
    localparam int TIMEOUT  = 64;
    localparam int SAT_LIM  = 4505;   // 16'h1199

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] core_z0;
    logic        core_rst;
    logic [15:0] cur_val;
    logic        core_flag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    int cur_delay = 1000;
    bit noise_en  = 1'b0;
    int run_idx   = -1;

    always #5 clk = ~clk;

    tanh_stream_adapter #(
        .SAT_LIMIT (16'h1199),
        .RST_HOLD  (RST_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_z0   (core_z0),
        .core_rst  (core_rst),
        .core_out  (cur_val),
        .core_flag (core_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: flag rises cur_delay cycles after reset release and stays high;
    // while held in reset the flag optionally toggles randomly (must be ignored).
    initial begin
        core_flag = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (core_rst) begin
                run_idx   = -1;
                core_flag = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                run_idx++;
                core_flag = (run_idx >= cur_delay);
            end
        end
    end

    // Behavioural expectation for one argument given the core's response delay
    function automatic void ref_model(input logic [15:0] z, input int delay, input logic [15:0] cval,
                                      output logic [15:0] d, output bit sat, output bit err,
                                      output int lat, output bit uses_core);
        int sz;
        sz = int'($signed(z));
        sat = 1'b0; err = 1'b0; uses_core = 1'b0;
        if (sz >= SAT_LIM) begin
            d = 16'h1000; sat = 1'b1; lat = 0;
        end else if (sz <= -SAT_LIM) begin
            d = 16'hF000; sat = 1'b1; lat = 0;
        end else begin
            uses_core = 1'b1;
            if (delay < TIMEOUT) begin
                d = cval; lat = RST_HOLD + delay + 1;
            end else begin
                d = 16'h0000; err = 1'b1; lat = RST_HOLD + TIMEOUT;
            end
        end
    endfunction

    // One full transaction; called and returns at 1 time unit after a rising edge
    task automatic run_op(input logic [15:0] z, input int delay, input logic [15:0] cval,
                          input int hold_cycles, input bit junk_in);
        logic [15:0] e_d;
        bit e_sat, e_err, uses_core;
        int e_lat, lat, w;
        bit rst_dropped, z0_bad, busy_bad, hold_bad;
        cur_delay = delay;
        cur_val   = cval;
        ref_model(z, delay, cval, e_d, e_sat, e_err, e_lat, uses_core);
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = z;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 0; rst_dropped = 0; z0_bad = 0; busy_bad = 0;
        while (!out_valid && lat < 300) begin
            if (!core_rst) rst_dropped = 1;
            if (in_ready) busy_bad = 1;
            if (uses_core && core_z0 !== z) z0_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(e_lat));
        check_eq("out_data", 32'(out_data), 32'(e_d));
        check_eq("out_sat", 32'(out_sat), 32'(e_sat));
        check_eq("out_err", 32'(out_err), 32'(e_err));
        check_eq("core_rst_dropped", 32'(rst_dropped), 32'(uses_core));
        check_eq("busy_in_ready", 32'(busy_bad), 32'd0);
        if (uses_core) check_eq("core_z0_stable", 32'(z0_bad), 32'd0);
        hold_bad = 0;
        for (int i = 0; i < hold_cycles; i++) begin
            if (junk_in) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            @(posedge clk); #1;
            if (!out_valid || in_ready || !core_rst || out_data !== e_d ||
                out_sat !== e_sat || out_err !== e_err) hold_bad = 1;
        end
        check_eq("hold_stable", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("consumed_valid", 32'(out_valid), 32'd0);
        check_eq("consumed_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int dly;
        int mode;
        logic [15:0] z;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        cur_val   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_core_rst", 32'(core_rst), 32'd1);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_core_z0", 32'(core_z0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(16'h0800, 20, 16'h0765, 2, 1'b0);
        run_op(16'h2000, 5, 16'h1234, 2, 1'b0);
        run_op(16'hE000, 5, 16'h1234, 2, 1'b0);
        run_op(16'h1199, 5, 16'h1234, 1, 1'b0);
        run_op(16'h1198, 7, 16'h0D9A, 1, 1'b0);
        run_op(16'hEE67, 5, 16'h1234, 1, 1'b0);
        run_op(16'hEE68, 3, 16'hF266, 1, 1'b0);
        run_op(16'h0000, 0, 16'h0000, 1, 1'b0);
        run_op(16'h0100, 1000, 16'h5555, 1, 1'b0);
        run_op(16'h0400, 9, 16'h03D6, 10, 1'b1);
        run_op(16'hFC00, 4, 16'hFC2A, 10, 1'b1);

        // Reset in the middle of RUN
        cur_delay = 1000;
        in_valid  = 1'b1;
        in_data   = 16'h0400;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (RST_HOLD + 5) begin
            @(posedge clk); #1;
        end
        check_eq("mid_run_core_rst", 32'(core_rst), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_core_rst", 32'(core_rst), 32'd1);
        check_eq("async_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_in_ready", 32'(in_ready), 32'd1);
        check_eq("async_core_z0", 32'(core_z0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(16'h0C00, 12, 16'h0A1B, 1, 1'b0);

        // Randomized arguments with a noisy flag while the core is held in reset
        noise_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: z = 16'($urandom);
                1: z = 16'(16'h1199 + 16'($urandom_range(0, 4)) - 16'd2);
                2: z = 16'(16'hEE67 + 16'($urandom_range(0, 4)) - 16'd2);
                default: z = 16'($signed(16'($urandom_range(0, 8190))) - 16'sd4095);
            endcase
            dly = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 40));
            run_op(z, dly, 16'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
